seq_detector_param: RTL
=======================

// Module: seq_detector_param
// PURPOSE
//   Parametrised Moore serial-pattern detector; successor to the fixed 4-bit "1101" detector.
//   Pattern, length and overlap mode are set per instance. Adds a sample enable, a synchronous
//   clear and a saturating match counter. Sits on a 1-bit serial input stream (switch/UART bit
//   level); drives an LED-style match flag and a count readout.
// PARAMETERS
//   PAT_W    4        pattern length in bits, 2..16
//   PATTERN  4'b1101  target pattern; PATTERN[PAT_W-1] is the first bit received
//   OVERLAP  1        1: matches may share bits; 0: a completed match consumes its bits
//   CNT_W    8        match counter width, 1..16
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active-low
//   in         in   1       serial data bit
//   in_en      in   1       sample enable; 'in' is consumed only on edges where in_en=1
//   clr        in   1       synchronous clear of state and counter
//   out        out  1       Moore match flag
//   match_cnt  out  CNT_W   number of matches since reset/clr, saturating
//   cnt_sat    out  1       1 while match_cnt equals all-ones
// BEHAVIOUR
//   - rst=0 (async, any time): state=0, out=0, match_cnt=0, cnt_sat=0; held until rst=1.
//   - State s = number of pattern prefix bits matched, 0..PAT_W; state register is clog2(PAT_W+1) bits.
//   - Next state on an edge with in_en=1, input b:
//       s<PAT_W            : s'=delta(s,b) (KMP: extend the prefix if PATTERN bit matches, else fall
//                            back along the failure function until it does, or reach 0)
//       s=PAT_W, OVERLAP=1 : s'=delta(fail(PAT_W),b)
//       s=PAT_W, OVERLAP=0 : s'=delta(0,b)
//     delta/fail tables are computed at elaboration from PATTERN; no runtime pattern load.
//   - in_en=0: state, out and counter hold.
//   - out = (s==PAT_W), registered state decode only. It rises in the cycle after the edge that
//     samples the final pattern bit and stays high until the next enabled sample leaves PAT_W.
//   - match_cnt increments by 1 on each edge where s' == PAT_W (entry or re-entry via overlap).
//     At all-ones it holds; cnt_sat=1 from then on until rst or clr.
//   - clr=1 at an edge: state=0, match_cnt=0, cnt_sat=0. Overrides in_en/in on the same edge,
//     so a final bit sampled with clr produces no match and no count.
//   - Reset mid-sequence discards all partial progress; the first post-reset bit is matched from s=0.
//   - No X propagation: all registers are reset; 'in' is ignored when in_en=0.
// STRUCTURE
//   - seq_det_pkg: state-width function clog2, function next_state(s,b,PATTERN,PAT_W,OVERLAP)
//     and fail() used to build the constant transition table; shared with any future
//     multi-channel detector.
//   - Sub-module seq_det_counter: CNT_W saturating counter with inc, clr and sat outputs.
//   - Top: state register, table lookup, out decode, counter instance.
// TESTING  (clk period 20 ns; rst held low 20 ns, then high; in_en=1 unless stated)
//   1. Default 1101, OVERLAP=1, stream 1,1,0,1,1,0,1 -> out high after bits 4 and 7; match_cnt=2.
//   2. Same stream, OVERLAP=0 -> out high after bit 4 only; match_cnt=1.
//   3. 1,1,0 then rst low 5 ns mid-cycle, release, then 1 -> out never high; match_cnt=0.
//   4. 1,1, in_en=0 for 3 cycles (in toggling), then 0,1 -> out high after the final 1;
//      match_cnt=1. Final 1 sampled together with clr=1 -> out=0, match_cnt=0.
//   5. CNT_W=2, four back-to-back 1101 -> match_cnt 1,2,3,3; cnt_sat=1 after 3rd match; out
//      still pulses on 4th.
//   6. PAT_W=3, PATTERN=3'b000, OVERLAP=1, five 0s -> out high after bits 3,4,5; match_cnt=3;
//      OVERLAP=0 -> match_cnt=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared helpers for serial pattern detectors: state width and the constant KMP transition function.
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int IDX_W     = 4;

  typedef logic [MAX_PAT_W-1:0] pattern_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Prefix bit idx of the pattern; bit 0 of the prefix is the first bit received.
  function automatic logic pat_bit(input pattern_t pat, input int pat_w, input int idx);
    return pat[IDX_W'(pat_w - 1 - idx)];
  endfunction

  function automatic int fail(input pattern_t pat, input int pat_w, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pat_bit(pat, pat_w, i) != pat_bit(pat, pat_w, len - k + i)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  // Longest pattern prefix that is a suffix of (prefix s followed by b); same result as KMP fallback.
  function automatic int delta(input pattern_t pat, input int pat_w, input int s, input logic b);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k <= s + 1; k++) begin
      if (k <= pat_w) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          j  = s + 1 - k + i;
          sb = (j < s) ? pat_bit(pat, pat_w, j) : b;
          if (pat_bit(pat, pat_w, i) != sb) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int next_state(input int s, input logic b, input pattern_t pat,
                                    input int pat_w, input bit overlap);
    if (s > pat_w) return 0;
    if (s == pat_w) return delta(pat, pat_w, overlap ? fail(pat, pat_w, pat_w) : 0, b);
    return delta(pat, pat_w, s, b);
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter with synchronous clear; sat flags the all-ones value.
module seq_det_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !sat)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with sample enable, synchronous clear and match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_en,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             SW      = clog2(PAT_W + 1);
  localparam int             DEPTH   = 1 << SW;
  localparam pattern_t       PAT_EXT = pattern_t'(PATTERN);
  localparam logic [SW-1:0]  FULL    = SW'(PAT_W);

  logic [SW-1:0] state;
  logic [SW-1:0] nxt;
  logic          hit;
  logic [SW-1:0] next_tab [DEPTH][2];

  // Transition table is folded to constants; unused state codes fall back to 0.
  for (genvar gs = 0; gs < DEPTH; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      assign next_tab[gs][gb] = SW'(next_state(gs, 1'(gb), PAT_EXT, PAT_W, OVERLAP));
    end
  end

  always_comb begin
    nxt = next_tab[state][in];
    hit = in_en && !clr && (nxt == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      out   <= 1'b0;
    end else if (clr) begin
      state <= '0;
      out   <= 1'b0;
    end else if (in_en) begin
      state <= nxt;
      out   <= (nxt == FULL);
    end
  end

  seq_det_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(clr),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule
